// File: rtl/proc_io_hub.sv
// proc_io_hub
// I/O hub between a soft processor's single-port I/O bus and NUM_CH external
// channels.
//
// Input side: every channel feeds a FIFO_DEPTH-entry FIFO. The processor reads
// one FIFO per cycle through a one-hot req_in. The head word appears on io_in
// combinationally, and the FIFO pops on the same clock edge.
//
// Output side: every channel has a holding register. A processor write loads it
// from io_out, and several channels may be written at once (broadcast).
//
// Sticky flags record reads of an empty FIFO (underflow) and writes that
// overwrite an unconsumed word (overrun).
//
// Ports
//   clk          clock, all state on rising edge
//   rst_geral_n  synchronous active-low reset
//   in_data      NUM_CH packed input words, channel i at [i*DATA_W +: DATA_W]
//   in_valid     producer has a word on channel i
//   in_ready     FIFO i can accept a word (low while in reset)
//   req_in       processor read request, one-hot
//   io_in        word returned to the processor (0 on an invalid read)
//   io_out       word written by the processor
//   out_en       processor write enables (broadcast allowed)
//   out_data     NUM_CH packed registered output words
//   out_valid    out_data channel i holds an unconsumed word
//   out_ready    consumer accepts out_data channel i
//   underflow    sticky: read of an empty FIFO
//   overrun      sticky: write over an unconsumed output word
//   status_clr   clears all sticky flags (a same-edge set wins)
module proc_io_hub #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_geral_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH-1:0]        req_in,
    output logic signed [DATA_W-1:0] io_in,
    input  logic signed [DATA_W-1:0] io_out,
    input  logic [NUM_CH-1:0]        out_en,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH-1:0]        underflow,
    output logic [NUM_CH-1:0]        overrun,
    input  logic                     status_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic signed [DATA_W-1:0] fifo_mem [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr   [NUM_CH];
    logic [AW-1:0]            rd_ptr   [NUM_CH];
    logic [CW-1:0]            count    [NUM_CH];
    logic signed [DATA_W-1:0] out_reg  [NUM_CH];

    logic [NUM_CH-1:0] req_ok;
    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] under_set;
    logic [NUM_CH-1:0] over_set;

    // Handshake and read decode. in_ready depends only on the registered count,
    // so a pop in this cycle does not free a slot until the next one.
    always_comb begin
        req_ok    = $onehot(req_in) ? req_in : '0;
        not_empty = '0;
        in_ready  = '0;
        push      = '0;
        pop       = '0;
        under_set = '0;
        over_set  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            not_empty[i] = (count[i] != '0);
            in_ready[i]  = (count[i] != FULL) & rst_geral_n;
            push[i]      = in_valid[i] & in_ready[i];
            // A read only succeeds on a FIFO that is already non-empty.
            // A push landing on the same edge is not forwarded.
            pop[i]       = req_ok[i] & not_empty[i];
            under_set[i] = req_ok[i] & ~not_empty[i];
            over_set[i]  = out_en[i] & out_valid[i] & ~out_ready[i];
        end
    end

    // Processor read port: head of the selected FIFO, or 0 on an invalid read.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pop[i]) begin
                io_in = fifo_mem[i][rd_ptr[i]];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_data[i*DATA_W +: DATA_W] = out_reg[i];
        end
    end

    // FIFO storage. It needs no reset because the pointers and counts define
    // which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO control, output registers and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_geral_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
                count[i]   <= '0;
                out_reg[i] <= '0;
            end
            out_valid <= '0;
            underflow <= '0;
            overrun   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                if (out_en[i]) begin
                    out_reg[i] <= io_out;
                end
            end
            // A write keeps the channel valid even while the old word is consumed.
            out_valid <= out_en | (out_valid & ~out_ready);
            underflow <= under_set | (underflow & ~{NUM_CH{status_clr}});
            overrun   <= over_set  | (overrun   & ~{NUM_CH{status_clr}});
        end
    end

endmodule
